// File: rtl/keypad_scan_controller.sv
// Keypad scan control FSM: scan, synchronize, debounce, re-check,
// send one key, then wait for a filtered release.
//
// Ports:
//   clk                  system clock, rising edge
//   reset                asynchronous active-low reset
//   buttonpush           any row active on the current column
//   synch_done           synchronizer snapshot loaded
//   debounce_done        debounce counter terminal count
//   post_debounce        re-check result while check_again=1
//   scan_counter_en      advance the column scan (SCAN)
//   WE_synch             synchronizer write enable (SYNCH)
//   debouncer_counter_en debounce counter enable (DEBOUNCE)
//   check_again          re-check request (CHECK)
//   WE_send              load decoded key, one pulse per key (SEND)
//   busy                 high in SYNCH..HOLD
//   abort                one-cycle pulse on watchdog expiry
//   reject               one-cycle pulse on failed re-check
//   state_dbg            current state encoding

module keypad_scan_controller #(
    parameter int WATCHDOG_CYCLES = 1000000,
    parameter int RELEASE_CYCLES  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       buttonpush,
    input  logic       synch_done,
    input  logic       debounce_done,
    input  logic       post_debounce,
    output logic       scan_counter_en,
    output logic       WE_synch,
    output logic       debouncer_counter_en,
    output logic       check_again,
    output logic       WE_send,
    output logic       busy,
    output logic       abort,
    output logic       reject,
    output logic [2:0] state_dbg
);

    localparam int WD_W =
        (WATCHDOG_CYCLES > 1) ? $clog2(WATCHDOG_CYCLES) : 1;
    localparam int REL_W =
        (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;

    localparam logic [WD_W-1:0] WD_LAST =
        WD_W'(WATCHDOG_CYCLES - 1);
    localparam logic [REL_W-1:0] REL_LAST =
        REL_W'(RELEASE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SCAN     = 3'd1,
        SYNCH    = 3'd2,
        DEBOUNCE = 3'd3,
        CHECK    = 3'd4,
        SEND     = 3'd5,
        HOLD     = 3'd6
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             abort_nxt;
    logic             reject_nxt;
    logic [WD_W-1:0]  wd_cnt;
    logic [REL_W-1:0] rel_cnt;
    logic             wd_expired;
    logic             rel_done;

    assign wd_expired = (wd_cnt == WD_LAST);
    assign rel_done   = (rel_cnt == REL_LAST);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus event pulses.
    // A done flag takes priority over a simultaneous expiry.
    always_comb begin
        state_nxt  = state;
        abort_nxt  = 1'b0;
        reject_nxt = 1'b0;
        unique case (state)
            IDLE: begin
                state_nxt = SCAN;
            end
            SCAN: begin
                if (buttonpush) begin
                    state_nxt = SYNCH;
                end
            end
            SYNCH: begin
                if (synch_done) begin
                    state_nxt = DEBOUNCE;
                end else if (wd_expired) begin
                    state_nxt = SCAN;
                    abort_nxt = 1'b1;
                end
            end
            DEBOUNCE: begin
                if (debounce_done) begin
                    state_nxt = CHECK;
                end else if (wd_expired) begin
                    state_nxt = SCAN;
                    abort_nxt = 1'b1;
                end
            end
            CHECK: begin
                if (post_debounce) begin
                    state_nxt = SEND;
                end else begin
                    state_nxt  = SCAN;
                    reject_nxt = 1'b1;
                end
            end
            SEND: begin
                state_nxt = HOLD;
            end
            HOLD: begin
                if (!buttonpush && rel_done) begin
                    state_nxt = SCAN;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Watchdog: any state change clears it, so it starts at 0
    // on entry to SYNCH and again on entry to DEBOUNCE.
    // It saturates at the expiry value instead of wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt <= '0;
        end else if (state_nxt != state) begin
            wd_cnt <= '0;
        end else if ((state == SYNCH || state == DEBOUNCE)
                     && !wd_expired) begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

    // Release filter: counts consecutive low cycles in HOLD,
    // any high cycle restarts the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rel_cnt <= '0;
        end else if (state != HOLD || buttonpush) begin
            rel_cnt <= '0;
        end else if (!rel_done) begin
            rel_cnt <= rel_cnt + REL_W'(1);
        end
    end

    // Outputs registered from the next-state decode so they
    // line up with the state register and have no input path.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_counter_en      <= 1'b0;
            WE_synch             <= 1'b0;
            debouncer_counter_en <= 1'b0;
            check_again          <= 1'b0;
            WE_send              <= 1'b0;
            busy                 <= 1'b0;
            abort                <= 1'b0;
            reject               <= 1'b0;
        end else begin
            scan_counter_en      <= (state_nxt == SCAN);
            WE_synch             <= (state_nxt == SYNCH);
            debouncer_counter_en <= (state_nxt == DEBOUNCE);
            check_again          <= (state_nxt == CHECK);
            WE_send              <= (state_nxt == SEND);
            busy                 <= (state_nxt == SYNCH)
                                 || (state_nxt == DEBOUNCE)
                                 || (state_nxt == CHECK)
                                 || (state_nxt == SEND)
                                 || (state_nxt == HOLD);
            abort                <= abort_nxt;
            reject               <= reject_nxt;
        end
    end

    assign state_dbg = state;

endmodule
